// File: rtl/btn_hex_counter.sv
// Two-button up/down hex counter for the 7-segment display path.
// Each raw button goes through a 2-flop synchronizer and a 4-state
// debouncer. A clean ZERO->ONE transition emits a single-cycle press
// event. The count register combines the two press events with a
// synchronous clear.

module btn_debounce #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int TW        = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press
);
  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;

  localparam logic [TW-1:0] LOAD = TW'(DB_CYCLES - 1);

  logic          s1, s2;
  state_t        state;
  logic [TW-1:0] timer;

  // Bring the asynchronous button into the clk domain; the FSM only sees s2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Debounce FSM. level is registered alongside the state.
  // The timer only counts down while it is nonzero, so it never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ZERO;
      timer <= '0;
      level <= 1'b0;
    end else begin
      case (state)
        ZERO: begin
          if (s2) begin
            state <= WAIT1;
            timer <= LOAD;
          end
        end
        WAIT1: begin
          if (!s2) begin
            state <= ZERO;
          end else if (timer == '0) begin
            state <= ONE;
            level <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ONE: begin
          if (!s2) begin
            state <= WAIT0;
            timer <= LOAD;
          end
        end
        WAIT0: begin
          if (s2) begin
            state <= ONE;
          end else if (timer == '0) begin
            state <= ZERO;
            level <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state <= ZERO;
          level <= 1'b0;
        end
      endcase
    end
  end

  // The press fires on the same edge that moves WAIT1 to ONE, so the
  // counter can update in step with the level change.
  assign press = (state == WAIT1) && s2 && (timer == '0);
endmodule

module btn_hex_counter #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int TW        = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       clr,
  output logic [7:0] count,
  output logic       up_level,
  output logic       down_level,
  output logic       step
);
  localparam int NUM_BTN = 2;

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] lvl;
  logic [NUM_BTN-1:0] prs;

  // Lane 0 is the up button, lane 1 is the down button.
  assign raw = {btn_down, btn_up};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES),
      .TW       (TW)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .btn  (raw[i]),
      .level(lvl[i]),
      .press(prs[i])
    );
  end

  assign up_level   = lvl[0];
  assign down_level = lvl[1];

  // Clear wins over presses. Simultaneous up+down presses cancel out.
  // The count wraps naturally at 8 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 8'h00;
      step  <= 1'b0;
    end else begin
      step <= 1'b0;
      if (clr) begin
        count <= 8'h00;
      end else if (prs[0] && !prs[1]) begin
        count <= count + 8'd1;
        step  <= 1'b1;
      end else if (prs[1] && !prs[0]) begin
        count <= count - 8'd1;
        step  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_btn_hex_counter.sv
// Scoreboard bench for btn_hex_counter (DB_CYCLES=4, TW=3).
// The reference model treats debouncing as "the synchronized input must
// disagree with the current level for DB_CYCLES+1 consecutive samples".
// It pushes the expected outputs for every edge. A separate monitor pops
// those entries and compares them against the DUT.

module tb_btn_hex_counter;
  localparam int DB = 4;
  localparam int TW = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] count;
  logic       up_level, down_level, step;

  btn_hex_counter #(.DB_CYCLES(DB), .TW(TW)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .clr       (clr),
    .count     (count),
    .up_level  (up_level),
    .down_level(down_level),
    .step      (step)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] count;
    logic       up;
    logic       dn;
    logic       step;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference model state.
  int          m_cnt;
  logic        m_step;
  logic [1:0]  m_lvl, m_d1, m_d2, m_raw, m_ev, m_s;
  int          m_run[2];

  // Model: the 2-edge input delay, then run-length debounce, then counter rules.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_cnt = 0; m_step = 1'b0; m_lvl = '0; m_d1 = '0; m_d2 = '0;
        m_run[0] = 0; m_run[1] = 0;
      end else begin
        m_raw = {btn_down, btn_up};
        m_s   = m_d2;
        m_d2  = m_d1;
        m_d1  = m_raw;
        m_ev  = '0;
        for (int i = 0; i < 2; i++) begin
          if (m_s[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == DB + 1) begin
              m_lvl[i] = m_s[i];
              m_run[i] = 0;
              m_ev[i]  = m_s[i];
            end
          end else begin
            m_run[i] = 0;
          end
        end
        m_step = 1'b0;
        if (clr) m_cnt = 0;
        else if (m_ev == 2'b01) begin m_cnt = (m_cnt + 1) % 256; m_step = 1'b1; end
        else if (m_ev == 2'b10) begin m_cnt = (m_cnt + 255) % 256; m_step = 1'b1; end
      end
      q.push_back('{count: m_cnt[7:0], up: m_lvl[0], dn: m_lvl[1], step: m_step});
    end
  end

  // Monitor: one expected entry per edge, checked shortly after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL sb_underflow: got empty queue expected entry at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("sb_count", count, e.count);
        chk("sb_up_level", up_level, e.up);
        chk("sb_down_level", down_level, e.dn);
        chk("sb_step", step, e.step);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic press(input bit dn, input int hold, input int rel);
    if (dn) btn_down = 1'b1; else btn_up = 1'b1;
    cyc(hold);
    btn_up = 1'b0; btn_down = 1'b0;
    cyc(rel);
  endtask

  initial begin
    cyc(3);
    chk("reset_count", count, 8'h00);
    chk("reset_levels", {up_level, down_level, step}, 3'b000);
    reset = 1'b0;
    cyc(2);

    // Clean press: count changes on the 7th edge, step lasts one cycle.
    btn_up = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #3;
      if (k == 6) chk("clean_before", count, 8'h00);
      if (k == 7) begin
        chk("clean_count", count, 8'h01);
        chk("clean_step", step, 1'b1);
        chk("clean_level", up_level, 1'b1);
      end
      if (k == 8) chk("clean_step_off", step, 1'b0);
    end
    cyc(12);
    chk("hold_no_repeat", count, 8'h01);
    btn_up = 1'b0;
    cyc(10);

    // Bounce: never stable long enough to register.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      btn_up = ((i % 3) != 2);
      cyc(1);
    end
    btn_up = 1'b0;
    cyc(12);
    chk("bounce_count", count, 8'h00);
    chk("bounce_level", up_level, 1'b0);

    // Wrap downward, then wrap upward.
    do_reset();
    press(1, 10, 10); chk("wrap_ff", count, 8'hFF);
    press(1, 10, 10); chk("wrap_fe", count, 8'hFE);
    press(1, 10, 10); chk("wrap_fd", count, 8'hFD);
    do_reset();
    press(1, 10, 10); chk("load_ff", count, 8'hFF);
    press(0, 10, 10); chk("wrap_00", count, 8'h00);

    // Simultaneous presses cancel out.
    do_reset();
    btn_up = 1'b1; btn_down = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #3;
      if (k == 6) chk("simul_lvl_pre", {up_level, down_level}, 2'b00);
      if (k == 7) chk("simul_lvl", {up_level, down_level}, 2'b11);
      if (k >= 7) chk("simul_cnt_step", {count, step}, 9'h000);
    end
    btn_up = 1'b0; btn_down = 1'b0;
    cyc(10);

    // Clear coincident with an up event.
    do_reset();
    for (int i = 0; i < 5; i++) press(0, 10, 10);
    chk("clr_pre", count, 8'h05);
    btn_up = 1'b1;
    cyc(6);
    clr = 1'b1;
    @(posedge clk); #3;
    chk("clr_evt_count", count, 8'h00);
    chk("clr_evt_step", step, 1'b0);
    chk("clr_evt_level", up_level, 1'b1);
    @(negedge clk);
    clr = 1'b0;
    btn_up = 1'b0;
    cyc(10);

    // Clear at an idle cycle from 0x37.
    for (int i = 0; i < 55; i++) press(0, 7, 8);
    chk("idle_clr_pre", count, 8'h37);
    clr = 1'b1;
    @(posedge clk); #3;
    chk("idle_clr", count, 8'h00);
    @(negedge clk);
    clr = 1'b0;
    cyc(2);

    // Async reset mid-WAIT1, then a fresh press with the button still held.
    press(0, 10, 10);
    chk("areset_pre", count, 8'h01);
    btn_up = 1'b1;
    cyc(4);
    #1 reset = 1'b1;
    #1;
    chk("areset_now", {count, up_level, down_level, step}, 11'h000);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #3;
      if (k == 6) chk("areset_before", count, 8'h00);
      if (k == 7) chk("areset_press", count, 8'h01);
    end
    @(negedge clk);
    btn_up = 1'b0;
    cyc(10);

    // Randomized segments of button levels with occasional clears.
    do_reset();
    for (int s = 0; s < 400; s++) begin
      int len;
      len      = $urandom_range(1, 12);
      btn_up   = ($urandom_range(0, 2) != 0);
      btn_down = ($urandom_range(0, 3) == 0);
      clr      = ($urandom_range(0, 24) == 0);
      cyc(1);
      clr = 1'b0;
      if (len > 1) cyc(len - 1);
    end
    btn_up = 1'b0; btn_down = 1'b0;
    cyc(12);
    @(posedge clk); #5;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/btn_hex_counter.md
Name: btn_hex_counter

Overview:
- Upstream value source for the 7-segment display path. Debounces two push-buttons (up, down) and maintains an 8-bit wrap-around count.
- The count's nibbles feed the hex_to_sseg decoders, which drive disp_mux.
- Replaces raw slide-switch input with a press-driven, glitch-free counter.

Parameters:
- DB_CYCLES, 1_000_000, clock cycles a button must stay stable before a level change is accepted (10 ms at 100 MHz); must be >= 1.
- TW, 20, width of the debounce timer; must satisfy 2^TW >= DB_CYCLES.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- btn_up  input  1  raw, asynchronous up button, active-high
- btn_down  input  1  raw, asynchronous down button, active-high
- clr  input  1  synchronous clear, already clean, active-high
- count  output  8  current count; [3:0] low digit, [7:4] high digit
- up_level  output  1  debounced level of btn_up
- down_level  output  1  debounced level of btn_down
- step  output  1  one-cycle pulse when count changes due to a button

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: count=0x00, up_level=0, down_level=0, step=0, all synchronizers=0, both FSMs in ZERO, timers=0.
- Synchronizer: each button passes through a 2-flop synchronizer (s1, s2). The FSM reads s2 only.
- Debouncer: one per button, identical. States ZERO, WAIT1, ONE, WAIT0.
  - ZERO: if s2=1, go to WAIT1 and load timer with DB_CYCLES-1.
  - WAIT1: if s2=0, go to ZERO (no pulse). Else if timer==0, go to ONE and assert a press event for that cycle. Else decrement timer.
  - ONE: if s2=0, go to WAIT0 and load timer with DB_CYCLES-1.
  - WAIT0: if s2=1, go to ONE. Else if timer==0, go to ZERO. Else decrement timer.
  - level=1 in ONE and WAIT0; level=0 in ZERO and WAIT1. Registered with the state.
- Press event: generated only on the ZERO→ONE path. Release never generates an event. Holding a button gives exactly one event (no auto-repeat).
- Latency: with btn held high from before rising edge E0, count changes on edge E0+DB_CYCLES+2, i.e. the (DB_CYCLES+3)th edge. step is high for exactly the cycle following that edge.
- Count update, evaluated on each edge in this priority order:
  1. clr=1: count←0x00, step=0. Any coincident press events are discarded.
  2. up event only: count←count+1 mod 256.
  3. down event only: count←count-1 mod 256.
  4. Both events in the same cycle: count unchanged, step=0.
  5. Otherwise: hold.
- Wrap: 0xFF+1 = 0x00; 0x00-1 = 0xFF. No saturation, no carry output.
- Timer: TW bits, unsigned, never underflows. It is only decremented when nonzero.
- Reset mid-operation: asynchronous return to reset values regardless of state. A button held through reset deassertion produces a fresh press after full latency.
- Bounce: any s2 toggle during WAIT1 aborts the press. Any toggle during WAIT0 returns to ONE, so no second press fires until a full DB_CYCLES stable-low period has elapsed.

Test Plan (DB_CYCLES=4, TW=3):
- Clean press: reset, then btn_up=1 held 20 cycles → count 0x00→0x01 on the 7th edge; step high exactly 1 cycle; up_level=1; no further change while held.
- Bounce: btn_up pulses high 2 cycles, low 1, high 2, low, repeated for 15 cycles, then stays low → count stays 0x00; step never asserts; up_level stays 0.
- Wrap: 3 clean down presses from reset → count 0xFF, 0xFE, 0xFD. Load to 0xFF, then a clean up press → 0x00.
- Simultaneous: btn_up and btn_down rise on the same edge and are held → both levels go to 1 on the same edge; count unchanged; step=0.
- Clear priority: clr=1 in the exact cycle an up event fires with count=0x05 → count=0x00, step=0. clr=1 at an idle cycle with count=0x37 → 0x00 on the next edge.
- Async reset: reset asserted mid-WAIT1 between clock edges → count, levels and step are 0 immediately. After release with btn_up still held, count becomes 0x01 exactly 7 edges later.
